// File: rtl/serial_frame_arbiter.sv
// Round-robin arbiter for four requesters feeding one serial display line.
// Each grant shifts out {start, port[1:0], payload MSB-first, stop} then idles for a gap.
module serial_frame_arbiter #(
  parameter int DATA_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            gnt,
  output logic                  SerOut,
  output logic                  busy,
  output logic [1:0]            cur_pn,
  output logic [2:0]            state_dbg
);

  // Handshake: req[i] is a level held until gnt[i] pulses for one cycle;
  // that pulse marks the cycle after req_data[i] and the port index were latched.

  localparam int MAX_CNT = (DATA_W > GAP_CYCLES) ? DATA_W : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
  localparam int SH_W    = DATA_W + 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PORT  = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [1:0]         ptr_q, ptr_nxt;
  logic [SH_W-1:0]    sh_q;
  logic [3:0]         gnt_nxt;
  logic               ser_nxt;
  logic               grant;
  logic               shifting;
  logic               found;
  logic [1:0]         win;
  logic [1:0]         cand;
  logic [DATA_W-1:0]  win_data;

  // Search upward from the pointer; first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    for (int off = 0; off < 4; off++) begin
      cand = ptr_q + 2'(off);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_data = req_data[int'(win)*DATA_W +: DATA_W];

  always_comb begin
    state_nxt = state_q;
    grant     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant     = 1'b1;
          state_nxt = START;
        end
      end
      START: state_nxt = PORT;
      PORT:  if (int'(cnt_q) == 1) state_nxt = DATA;
      DATA:  if (int'(cnt_q) == DATA_W - 1) state_nxt = STOP;
      STOP:  state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:   if (int'(cnt_q) >= GAP_CYCLES - 1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign shifting = (state_q == START) || (state_q == PORT) || (state_q == DATA);

  always_comb begin
    cnt_nxt = (state_nxt != state_q) ? '0 : cnt_q + 1'b1;
    ptr_nxt = grant ? (win + 2'd1) : ptr_q;
    gnt_nxt = grant ? (4'b0001 << win) : 4'b0000;
    ser_nxt = 1'b1;
    if (grant)
      ser_nxt = 1'b0;
    else if (shifting)
      ser_nxt = sh_q[SH_W-1];
  end

  // The start bit is driven directly at grant; the shifter holds the rest of the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      cur_pn  <= '0;
      sh_q    <= '1;
      SerOut  <= 1'b1;
      gnt     <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      ptr_q   <= ptr_nxt;
      gnt     <= gnt_nxt;
      SerOut  <= ser_nxt;
      if (grant) begin
        cur_pn <= win;
        sh_q   <= {win, win_data, 1'b1};
      end else if (shifting) begin
        sh_q   <= {sh_q[SH_W-2:0], 1'b1};
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Bench for serial_frame_arbiter: default instance plus a GAP_CYCLES=0 instance,
// frames checked bit by bit against a queue of expected line values.
module tb_serial_frame_arbiter;

  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    req, req0;
  logic [4*DW-1:0] req_data, req_data0;
  logic [3:0]    gnt, gnt0;
  logic          ser, ser0;
  logic          busy, busy0;
  logic [1:0]    cur_pn, cur_pn0;
  logic [2:0]    state_dbg, state_dbg0;

  logic [0:0]    exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;

  serial_frame_arbiter #(.DATA_W(DW), .GAP_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .SerOut(ser), .busy(busy), .cur_pn(cur_pn), .state_dbg(state_dbg)
  );

  serial_frame_arbiter #(.DATA_W(DW), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .req_data(req_data0), .gnt(gnt0),
    .SerOut(ser0), .busy(busy0), .cur_pn(cur_pn0), .state_dbg(state_dbg0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [1:0] pn, input logic [DW-1:0] d);
    exp_q.push_back(1'b0);
    exp_q.push_back(pn[1]);
    exp_q.push_back(pn[0]);
    for (int b = DW - 1; b >= 0; b--) exp_q.push_back(d[b]);
    exp_q.push_back(1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    req = 4'($urandom_range(1, 15));
    req_data = 16'($urandom);
    repeat (3) tick();
    n_cmp++; if (ser !== 1'b1) begin n_bad++; $display("FAIL reset_ser: got %b want 1", ser); end
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (cur_pn !== 2'b00) begin n_bad++; $display("FAIL reset_pn: got %b want 00", cur_pn); end
    req = 4'b0000;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if ({ser, gnt, busy, cur_pn} !== 8'b1_0000_0_00) begin
        n_bad++;
        $display("FAIL idle_hold[%0d]: got %b want 10000000", i, {ser, gnt, busy, cur_pn});
      end
    end
  endtask

  task automatic test_single_frame();
    logic e;
    req_data = 16'($urandom);
    req_data[11:8] = 4'b1010;
    req = 4'b0100;
    push_frame(2'd2, 4'b1010);
    tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    n_cmp++; if (cur_pn !== 2'd2) begin n_bad++; $display("FAIL single_pn: got %0d want 2", cur_pn); end
    req = 4'b0000;
    for (int k = 0; k < 4 + DW; k++) begin
      e = exp_q.pop_front();
      n_cmp++; if (ser !== e) begin n_bad++; $display("FAIL single_bit%0d: got %b want %b", k, ser, e); end
      if (k == 1) begin
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_gnt_pulse: got %b want 0000", gnt); end
      end
      tick();
    end
    n_cmp++; if ({busy, ser} !== 2'b11) begin n_bad++; $display("FAIL single_gap: got busy,ser=%b want 11", {busy, ser}); end
    tick();
    n_cmp++; if ({busy, ser} !== 2'b01) begin n_bad++; $display("FAIL single_idle: got busy,ser=%b want 01", {busy, ser}); end
    n_cmp++; if (cur_pn !== 2'd2) begin n_bad++; $display("FAIL single_pn_hold: got %0d want 2", cur_pn); end
  endtask

  task automatic test_round_robin();
    int last, w;
    logic [1:0] pn;
    logic e;
    last = 0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req_data = 16'hD693;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (gnt === 4'b0000 && w < 30) begin tick(); w++; end
      pn = 2'(g % 4);
      n_cmp++; if (gnt !== (4'b0001 << pn)) begin n_bad++; $display("FAIL rr_gnt%0d: got %b want %b", g, gnt, 4'b0001 << pn); end
      if (g > 0) begin
        n_cmp++; if (cyc - last != 10) begin n_bad++; $display("FAIL rr_period%0d: got %0d want 10", g, cyc - last); end
      end
      last = cyc;
      if (g == 4) req = 4'b0000;
      push_frame(pn, req_data[int'(pn)*DW +: DW]);
      for (int k = 0; k < 4 + DW; k++) begin
        e = exp_q.pop_front();
        n_cmp++; if (ser !== e) begin n_bad++; $display("FAIL rr_frame%0d_bit%0d: got %b want %b", g, k, ser, e); end
        tick();
      end
    end
  endtask

  task automatic test_pointer_skip();
    int w;
    logic [1:0] pn;
    logic e;
    req = 4'b0100;
    for (int g = 0; g < 3; g++) begin
      w = 0;
      while (gnt === 4'b0000 && w < 30) begin tick(); w++; end
      pn = (g == 1) ? 2'd0 : 2'd2;
      n_cmp++; if (gnt !== (4'b0001 << pn)) begin n_bad++; $display("FAIL skip_gnt%0d: got %b want %b", g, gnt, 4'b0001 << pn); end
      n_cmp++; if (cur_pn !== pn) begin n_bad++; $display("FAIL skip_pn%0d: got %0d want %0d", g, cur_pn, pn); end
      req = (g == 0) ? 4'b0101 : (g == 1) ? 4'b0100 : 4'b0000;
      push_frame(pn, req_data[int'(pn)*DW +: DW]);
      for (int k = 0; k < 4 + DW; k++) begin
        e = exp_q.pop_front();
        n_cmp++; if (ser !== e) begin n_bad++; $display("FAIL skip_frame%0d_bit%0d: got %b want %b", g, k, ser, e); end
        tick();
      end
    end
  endtask

  task automatic test_midframe_changes();
    int w;
    logic e;
    req_data = 16'($urandom);
    req_data[7:4] = 4'b0110;
    req = 4'b0010;
    w = 0;
    while (gnt === 4'b0000 && w < 30) begin tick(); w++; end
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL mid_gnt: got %b want 0010", gnt); end
    push_frame(2'd1, 4'b0110);
    for (int k = 0; k < 4 + DW; k++) begin
      e = exp_q.pop_front();
      n_cmp++; if (ser !== e) begin n_bad++; $display("FAIL mid_bit%0d: got %b want %b", k, ser, e); end
      if (k >= 3 && k <= 6) begin
        req = 4'($urandom_range(0, 15));
        req_data = 16'($urandom);
      end
      if (k == 7) req = 4'b0000;
      tick();
    end
    tick();
    n_cmp++; if ({busy, gnt} !== 5'b0_0000) begin n_bad++; $display("FAIL mid_idle: got busy,gnt=%b want 00000", {busy, gnt}); end

    req = 4'b1000;
    w = 0;
    while (gnt === 4'b0000 && w < 30) begin tick(); w++; end
    n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL abort_gnt: got %b want 1000", gnt); end
    req = 4'b0000;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (ser !== 1'b1) begin n_bad++; $display("FAIL abort_ser: got %b want 1", ser); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (cur_pn !== 2'd0) begin n_bad++; $display("FAIL abort_pn: got %0d want 0", cur_pn); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({ser, gnt, busy} !== 6'b1_0000_0) begin
        n_bad++;
        $display("FAIL abort_idle[%0d]: got %b want 100000", i, {ser, gnt, busy});
      end
    end
  endtask

  task automatic test_gap_zero();
    int last, w;
    logic [1:0] pn;
    logic e;
    last = 0;
    req_data0 = 16'h00C5;
    req0 = 4'b0011;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      while (gnt0 === 4'b0000 && w < 30) begin tick(); w++; end
      pn = 2'(g % 2);
      n_cmp++; if (gnt0 !== (4'b0001 << pn)) begin n_bad++; $display("FAIL gap0_gnt%0d: got %b want %b", g, gnt0, 4'b0001 << pn); end
      if (g > 0) begin
        n_cmp++; if (cyc - last != 9) begin n_bad++; $display("FAIL gap0_period%0d: got %0d want 9", g, cyc - last); end
      end
      last = cyc;
      if (g == 3) req0 = 4'b0000;
      push_frame(pn, req_data0[int'(pn)*DW +: DW]);
      for (int k = 0; k < 4 + DW; k++) begin
        e = exp_q.pop_front();
        n_cmp++; if (ser0 !== e) begin n_bad++; $display("FAIL gap0_frame%0d_bit%0d: got %b want %b", g, k, ser0, e); end
        tick();
      end
    end
    n_cmp++; if ({busy0, ser0} !== 2'b01) begin n_bad++; $display("FAIL gap0_idle: got busy,ser=%b want 01", {busy0, ser0}); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b0;
    req = 4'b0000;
    req0 = 4'b0000;
    req_data = '0;
    req_data0 = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_pointer_skip();
    test_midframe_changes();
    test_gap_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_arbiter.md
# serial_frame_arbiter

Round-robin arbiter and serializer that lets up to four requesters share the single serial line feeding the multi-segment display receiver. It grants one requester at a time and latches that requester's port number and 4-bit payload. It then shifts a complete frame onto the line and enforces an idle gap before the next arbitration. Sits upstream of the serial display receiver and drives its serial input.

## Interface
- DATA_W, 4: payload bits per frame.
- GAP_CYCLES, 1: minimum line-idle cycles (line = 1) after each stop bit; 0 allowed.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- req  input  4  level requests; req[i] held high until gnt[i] pulses.
- req_data  input  4*DATA_W  payload of requester i at bits [i*DATA_W +: DATA_W].
- gnt  output  4  one-hot, one-cycle pulse; the cycle requester i's payload was latched.
- SerOut  output  1  serial line, registered, idles high.
- busy  output  1  high whenever the FSM is not in IDLE.
- cur_pn  output  2  index of requester owning the current/last frame.

## Operation
- Frame, MSB first: start bit 0, then cur_pn[1], then cur_pn[0], then payload[DATA_W-1..0], then stop bit 1. That is 4+DATA_W line cycles.
- FSM states:
  - IDLE: SerOut=1. On an edge with req != 0, pick the winner, latch its index and payload, go to START.
  - START: SerOut=0, 1 cycle, then PORT.
  - PORT: 2 cycles, then DATA.
  - DATA: DATA_W cycles, then STOP.
  - STOP: SerOut=1, 1 cycle, then GAP, or IDLE if GAP_CYCLES=0.
  - GAP: SerOut=1 for GAP_CYCLES cycles, then IDLE.
- Round-robin: the pointer resets to 0. The search starts at the pointer and goes upward mod 4. The first set req wins. After granting i, pointer = (i+1) mod 4.
- req sampled only in IDLE. Requests rising or falling during a frame have no effect on that frame.
- Payload and index are latched at the grant edge. Later changes to req_data do not affect the frame.
- busy = (state != IDLE). cur_pn holds its value until the next grant.
- A bit counter is sized for max(DATA_W, GAP_CYCLES). It wraps to 0 on every state change.

## Timing
- Reset (rst=0, asynchronous, immediate): SerOut=1, gnt=0, busy=0, cur_pn=0, pointer=0, state=IDLE.
- Grant edge E (IDLE with req != 0):
  - In cycle E+1: gnt[i]=1, SerOut=0 (START), busy=1.
  - gnt returns to 0 at E+2.
- SerOut bit k of the frame appears in cycle E+1+k, for k = 0 .. 3+DATA_W.
- IDLE lasts at least 1 cycle. Back-to-back period under continuous requests is 5+DATA_W+GAP_CYCLES cycles (10 with defaults).
- A requester may drop req in the gnt cycle. A requester that keeps req high is re-eligible at the next IDLE.
- Reset mid-frame: the frame is aborted and SerOut goes high immediately. The aborted requester is not re-served automatically; it must re-request.
- Reset released while req is high: arbitration happens at the first rising edge after release.
- req=0 in IDLE: the FSM stays in IDLE and SerOut stays 1.

## Test plan
- Reset: hold rst=0 with random req. Required: SerOut=1, gnt=0000, busy=0, cur_pn=00. Release rst with req=0: outputs stay unchanged for 20 cycles.
- Single frame: req=0100, req_data[11:8]=1010. Required: gnt=0100 for one cycle, cur_pn=10, SerOut = 0,1,0,1,0,1,0,1. Then busy stays high for 1 GAP cycle, then IDLE.
- Round-robin: req=1111 held. Required: grants in order 0,1,2,3,0, spaced exactly 10 cycles apart.
- Pointer skip: grant requester 2, then req=0101. Required: next grant goes to 0; the one after goes to 2.
- Mid-frame changes: toggle req and req_data during DATA. Required: the frame content is unchanged. Assert rst=0 during DATA. Required: SerOut=1 within the same cycle and busy=0.
- GAP_CYCLES=0 instance with req=0011 held. Required: frame period of 9 cycles and alternating grants 0,1.
